// File: rtl/axi4_lite_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_regfile_slave
// Purpose  : AXI4-Lite slave in front of a bank of NUM_REGS registers, each
//            DATA_WIDTH bits wide. Supports byte strobes, per-register
//            read-only protection and OKAY/SLVERR/DECERR responses.
//            AW and W are accepted independently, in either order. B and R
//            are held until the master accepts them.
// Ports    : clk, reset (sync, active-high)
//            AW : awaddr_i, awvalid_i, awready_o
//            W  : wdata_i, wstrb_i, wvalid_i, wready_o
//            B  : bresp_o, bvalid_o, bready_i
//            AR : araddr_i, arvalid_i, arready_o
//            R  : rdata_o, rresp_o, rvalid_o, rready_i
//            regs_o : flattened register contents, reg i at [i*DW +: DW]
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_regfile_slave #(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          awaddr_i,
    input  logic                           awvalid_i,
    output logic                           awready_o,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic                           wvalid_i,
    output logic                           wready_o,
    output logic [1:0]                     bresp_o,
    output logic                           bvalid_o,
    input  logic                           bready_i,
    input  logic [ADDR_WIDTH-1:0]          araddr_i,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [1:0]                     rresp_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int         c_BYTES  = DATA_WIDTH / 8;
    localparam int         c_LSB    = $clog2(c_BYTES);
    localparam int         c_IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;
    localparam logic [1:0] c_DECERR = 2'b11;

    typedef enum logic [0:0] {W_ACCEPT = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_ACCEPT = 1'b0, R_RESP = 1'b1} rstate_t;

    // Misalignment takes priority over range; read-only is layered on by the
    // write path only.
    function automatic logic [1:0] f_decode(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] sh;
        sh = a >> c_LSB;
        if (a[c_LSB-1:0] != '0)
            return c_SLVERR;
        if (sh >= ADDR_WIDTH'(NUM_REGS))
            return c_DECERR;
        return c_OKAY;
    endfunction

    function automatic logic [c_IDX_W-1:0] f_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] sh;
        sh = a >> c_LSB;
        return sh[c_IDX_W-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t               r_wstate,   w_wstate_nx;
    logic                  r_aw_held,  w_aw_held_nx;
    logic                  r_w_held,   w_w_held_nx;
    logic [ADDR_WIDTH-1:0] r_awaddr,   w_awaddr_nx;
    logic [DATA_WIDTH-1:0] r_wdata,    w_wdata_nx;
    logic [c_BYTES-1:0]    r_wstrb,    w_wstrb_nx;
    logic                  r_awready,  w_awready_nx;
    logic                  r_wready,   w_wready_nx;
    logic                  r_bvalid,   w_bvalid_nx;
    logic [1:0]            r_bresp,    w_bresp_nx;
    logic [1:0]            w_wr_resp;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic                  w_commit;

    always_comb begin
        w_wstate_nx  = r_wstate;
        w_aw_held_nx = r_aw_held;
        w_w_held_nx  = r_w_held;
        w_awaddr_nx  = r_awaddr;
        w_wdata_nx   = r_wdata;
        w_wstrb_nx   = r_wstrb;
        w_awready_nx = r_awready;
        w_wready_nx  = r_wready;
        w_bvalid_nx  = r_bvalid;
        w_bresp_nx   = r_bresp;
        w_wr_resp    = c_OKAY;
        w_wr_idx     = '0;
        w_commit     = 1'b0;
        case (r_wstate)
            W_ACCEPT: begin
                if (awvalid_i && r_awready) begin
                    w_aw_held_nx = 1'b1;
                    w_awaddr_nx  = awaddr_i;
                end
                if (wvalid_i && r_wready) begin
                    w_w_held_nx = 1'b1;
                    w_wdata_nx  = wdata_i;
                    w_wstrb_nx  = wstrb_i;
                end
                // The completing handshake uses the just-captured values so
                // that same-cycle AW+W commits without an extra cycle.
                if (w_aw_held_nx && w_w_held_nx) begin
                    w_wr_resp = f_decode(w_awaddr_nx);
                    w_wr_idx  = f_index(w_awaddr_nx);
                    if (w_wr_resp == c_OKAY && RO_MASK[w_wr_idx])
                        w_wr_resp = c_SLVERR;
                    w_commit     = (w_wr_resp == c_OKAY);
                    w_bresp_nx   = w_wr_resp;
                    w_bvalid_nx  = 1'b1;
                    w_awready_nx = 1'b0;
                    w_wready_nx  = 1'b0;
                    w_wstate_nx  = W_RESP;
                end else begin
                    w_awready_nx = !w_aw_held_nx;
                    w_wready_nx  = !w_w_held_nx;
                end
            end
            W_RESP: begin
                if (r_bvalid && bready_i) begin
                    w_bvalid_nx  = 1'b0;
                    w_aw_held_nx = 1'b0;
                    w_w_held_nx  = 1'b0;
                    w_awready_nx = 1'b1;
                    w_wready_nx  = 1'b1;
                    w_wstate_nx  = W_ACCEPT;
                end
            end
            default: w_wstate_nx = W_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_ACCEPT;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
        end else begin
            r_wstate  <= w_wstate_nx;
            r_aw_held <= w_aw_held_nx;
            r_w_held  <= w_w_held_nx;
            r_awaddr  <= w_awaddr_nx;
            r_wdata   <= w_wdata_nx;
            r_wstrb   <= w_wstrb_nx;
            r_awready <= w_awready_nx;
            r_wready  <= w_wready_nx;
            r_bvalid  <= w_bvalid_nx;
            r_bresp   <= w_bresp_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int k = 0; k < c_BYTES; k++)
                if (w_wstrb_nx[k])
                    r_regs[w_wr_idx][8*k +: 8] <= w_wdata_nx[8*k +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Read channel. The register array is sampled before any same-edge
    // write lands, so a colliding read returns the pre-write value.
    // ------------------------------------------------------------------
    rstate_t               r_rstate,  w_rstate_nx;
    logic                  r_arready, w_arready_nx;
    logic                  r_rvalid,  w_rvalid_nx;
    logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_nx;
    logic [1:0]            r_rresp,   w_rresp_nx;
    logic [1:0]            w_rd_resp;
    logic [c_IDX_W-1:0]    w_rd_idx;

    always_comb begin
        w_rstate_nx  = r_rstate;
        w_arready_nx = r_arready;
        w_rvalid_nx  = r_rvalid;
        w_rdata_nx   = r_rdata;
        w_rresp_nx   = r_rresp;
        w_rd_resp    = f_decode(araddr_i);
        w_rd_idx     = f_index(araddr_i);
        case (r_rstate)
            R_ACCEPT: begin
                w_arready_nx = 1'b1;
                if (arvalid_i && r_arready) begin
                    w_rresp_nx   = w_rd_resp;
                    w_rdata_nx   = (w_rd_resp == c_OKAY) ? r_regs[w_rd_idx] : '0;
                    w_rvalid_nx  = 1'b1;
                    w_arready_nx = 1'b0;
                    w_rstate_nx  = R_RESP;
                end
            end
            R_RESP: begin
                if (r_rvalid && rready_i) begin
                    w_rvalid_nx  = 1'b0;
                    w_arready_nx = 1'b1;
                    w_rstate_nx  = R_ACCEPT;
                end
            end
            default: w_rstate_nx = R_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= R_ACCEPT;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_OKAY;
        end else begin
            r_rstate  <= w_rstate_nx;
            r_arready <= w_arready_nx;
            r_rvalid  <= w_rvalid_nx;
            r_rdata   <= w_rdata_nx;
            r_rresp   <= w_rresp_nx;
        end
    end

    assign awready_o = r_awready;
    assign wready_o  = r_wready;
    assign bvalid_o  = r_bvalid;
    assign bresp_o   = r_bresp;
    assign arready_o = r_arready;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;
    assign rresp_o   = r_rresp;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_regfile_slave
// Purpose  : Self-checking bench for axi4_lite_regfile_slave (8 x 32-bit,
//            register 7 read-only). A transaction-level model (memory array
//            plus expected responses) is checked every cycle by a compare
//            process; directed cases pin literal values, then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_regfile_slave;

    localparam logic [7:0] c_RO = 8'h80;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  awaddr_i, wdata_i, araddr_i;
    logic         awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;
    logic [3:0]   wstrb_i;
    logic         awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
    logic [1:0]   bresp_o, rresp_o;
    logic [31:0]  rdata_o;
    logic [255:0] regs_o;

    axi4_lite_regfile_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .RO_MASK(c_RO)
    ) dut (
        .clk(clk), .reset(reset),
        .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] mem [8];
    logic [1:0]  exp_b;
    logic [1:0]  exp_rr;
    logic [31:0] exp_rd;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Response rules: misaligned -> SLVERR, beyond 8 regs -> DECERR,
    // write to read-only register -> SLVERR, else OKAY.
    function automatic logic [1:0] model_resp(input logic [31:0] a, input bit is_write);
        if (a % 4 != 0) return 2'b10;
        if (a / 4 >= 8) return 2'b11;
        if (is_write && c_RO[a / 4]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = mem[i];
        return f;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("regs", regs_o, model_flat());
            if (bvalid_o) check("bresp", 256'(bresp_o), 256'(exp_b));
            if (rvalid_o) begin
                check("rresp", 256'(rresp_o), 256'(exp_rr));
                check("rdata", 256'(rdata_o), 256'(exp_rd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdelay, output logic [1:0] gb);
        logic [1:0] e;
        bit aw_done, w_done, hs_aw, hs_w;
        int aw_start, w_start, cyc;
        e = model_resp(a, 1'b1);
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done)) begin
            awaddr_i  = a; wdata_i = d; wstrb_i = s;
            awvalid_i = !aw_done && (cyc >= aw_start);
            wvalid_i  = !w_done && (cyc >= w_start);
            check("awready_accept", 256'(awready_o), 256'(!aw_done));
            check("wready_accept", 256'(wready_o), 256'(!w_done));
            check("no_early_b", 256'(bvalid_o), 256'(0));
            hs_aw = awvalid_i && awready_o;
            hs_w  = wvalid_i && wready_o;
            step();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
            cyc++;
            if (cyc > 20) begin
                check("write_handshake_timeout", 256'(0), 256'(1));
                break;
            end
        end
        awvalid_i = 0; wvalid_i = 0;
        if (e == 2'b00)
            for (int k = 0; k < 4; k++)
                if (s[k]) mem[a[4:2]][8*k +: 8] = d[8*k +: 8];
        exp_b = e;
        check("bvalid_latency", 256'(bvalid_o), 256'(1));
        gb = bresp_o;
        for (int i = 0; i < bdelay; i++) begin
            check("awready_busy", 256'(awready_o), 256'(0));
            check("wready_busy", 256'(wready_o), 256'(0));
            step();
            check("bvalid_held", 256'(bvalid_o), 256'(1));
        end
        bready_i = 1;
        step();
        bready_i = 0;
        check("bvalid_drop", 256'(bvalid_o), 256'(0));
        check("awready_back", 256'(awready_o), 256'(1));
        check("wready_back", 256'(wready_o), 256'(1));
    endtask

    task automatic do_read(input logic [31:0] a, input int rdelay,
                           output logic [31:0] gd, output logic [1:0] gr);
        logic [1:0] e;
        e = model_resp(a, 1'b0);
        exp_rr = e;
        exp_rd = (e == 2'b00) ? mem[a[4:2]] : 32'h0;
        check("arready_idle", 256'(arready_o), 256'(1));
        araddr_i = a; arvalid_i = 1;
        step();
        arvalid_i = 0;
        check("rvalid_latency", 256'(rvalid_o), 256'(1));
        gd = rdata_o; gr = rresp_o;
        for (int i = 0; i < rdelay; i++) begin
            check("arready_busy", 256'(arready_o), 256'(0));
            step();
            check("rvalid_held", 256'(rvalid_o), 256'(1));
        end
        rready_i = 1;
        step();
        rready_i = 0;
        check("rvalid_drop", 256'(rvalid_o), 256'(0));
        check("arready_back", 256'(arready_o), 256'(1));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  gb, gb2, gr;
        logic [31:0] gd, a;
        int op;
        reset = 1; awvalid_i = 0; wvalid_i = 0; bready_i = 0; arvalid_i = 0; rready_i = 0;
        awaddr_i = 0; wdata_i = 0; wstrb_i = 0; araddr_i = 0;
        exp_b = 0; exp_rr = 0; exp_rd = 0;
        for (int i = 0; i < 8; i++) mem[i] = 0;
        step(); step();
        check("rst_awready", 256'(awready_o), 256'(0));
        check("rst_wready", 256'(wready_o), 256'(0));
        check("rst_arready", 256'(arready_o), 256'(0));
        check("rst_valids", 256'({bvalid_o, rvalid_o}), 256'(0));
        check("rst_resps", 256'({bresp_o, rresp_o, rdata_o}), 256'(0));
        check("rst_regs", regs_o, 256'(0));
        reset = 0;
        step();
        check("readies_up", 256'({awready_o, wready_o, arready_o}), 256'(3'b111));

        // Same-cycle AW+W then read back.
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, gb);
        check("t1_bresp", 256'(gb), 256'(2'b00));
        do_read(32'h4, 0, gd, gr);
        check("t1_rdata", 256'(gd), 256'(32'hDEADBEEF));
        check("t1_rresp", 256'(gr), 256'(2'b00));
        // W three cycles ahead of AW.
        do_write(32'h8, 32'h11223344, 4'hF, 3, 0, gb);
        check("t2_reg2", 256'(regs_o[95:64]), 256'(32'h11223344));
        // Byte strobe merge.
        do_write(32'h0, 32'hFFFFFFFF, 4'hF, -2, 0, gb);
        do_write(32'h0, 32'h000000AA, 4'h1, 0, 0, gb);
        check("t3_reg0", 256'(regs_o[31:0]), 256'(32'hFFFFFFAA));
        // Error responses.
        do_write(32'h20, 32'h55555555, 4'hF, 0, 0, gb);
        check("t4_decerr", 256'(gb), 256'(2'b11));
        do_write(32'h6, 32'h55555555, 4'hF, 0, 0, gb);
        check("t5_slverr_misalign", 256'(gb), 256'(2'b10));
        do_write(32'h1C, 32'h55555555, 4'hF, 1, 0, gb);
        check("t6_slverr_ro", 256'(gb), 256'(2'b10));
        check("t6_reg7", 256'(regs_o[255:224]), 256'(0));
        do_read(32'h20, 0, gd, gr);
        check("t7_rresp", 256'(gr), 256'(2'b11));
        check("t7_rdata", 256'(gd), 256'(0));
        do_read(32'h1C, 0, gd, gr);
        check("t7_ro_read_okay", 256'(gr), 256'(2'b00));
        // Backpressure.
        do_write(32'hC, 32'hCAFEF00D, 4'hF, 0, 5, gb);
        do_read(32'hC, 5, gd, gr);
        check("t8_rdata", 256'(gd), 256'(32'hCAFEF00D));
        // Read colliding with a write commit to the same register.
        do_write(32'h10, 32'h00000001, 4'hF, 0, 0, gb);
        fork
            do_write(32'h10, 32'h00000002, 4'hF, 0, 0, gb2);
            do_read(32'h10, 0, gd, gr);
        join
        check("t9_prewrite", 256'(gd), 256'(32'h1));
        check("t9_reg4", 256'(regs_o[159:128]), 256'(32'h2));

        // Reset while B pending.
        awaddr_i = 32'h0; wdata_i = 32'h12345678; wstrb_i = 4'hF;
        awvalid_i = 1; wvalid_i = 1;
        step();
        awvalid_i = 0; wvalid_i = 0;
        mem[0] = 32'h12345678; exp_b = 2'b00;
        check("t10_bpending", 256'(bvalid_o), 256'(1));
        step();
        reset = 1;
        step();
        for (int i = 0; i < 8; i++) mem[i] = 0;
        reset = 0;
        check("t10_bvalid", 256'(bvalid_o), 256'(0));
        check("t10_regs", regs_o, 256'(0));
        check("t10_readies_rst", 256'({awready_o, wready_o, arready_o}), 256'(0));
        step();
        check("t10_readies_up", 256'({awready_o, wready_o, arready_o}), 256'(3'b111));

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 9) * 4);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            op = $urandom_range(0, 2);
            if (op == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3,
                         $urandom_range(0, 3), gb);
            else if (op == 1)
                do_read(a, $urandom_range(0, 3), gd, gr);
            else
                fork
                    do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3,
                             $urandom_range(0, 3), gb);
                    do_read(32'($urandom_range(0, 9) * 4), $urandom_range(0, 3), gd, gr);
                join
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
